persistence_pair_collector: RTL

Downstream stage of the parallel boundary-matrix reduction engine. Takes one reduced column at a time, as a column index, its lowest-one (pivot) row and a zero flag. Emits persistence pairs (birth = pivot row, death = column index) through an output FIFO. On request it scans for essential (never-killed) classes. Tracks pivot uniqueness and flags any pivot conflict, which indicates an incompletely reduced input.

---
 rtl/persistence_pair_collector.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/persistence_pair_collector.sv
// Collects (birth, death) persistence pairs from reduced columns into an output FIFO.
// Define PERSIST_ESSENTIAL_EN to build the zero map and the essential-class scan on flush.
module persistence_pair_collector #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned NUM_COLS        = 256,
  parameter int unsigned PAIR_FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDR_WIDTH-1:0]             in_col,
  input  logic [ADDR_WIDTH-1:0]             in_pivot,
  input  logic                              in_zero,
  input  logic                              flush,
  output logic                              pair_valid,
  input  logic                              pair_ready,
  output logic [ADDR_WIDTH-1:0]             pair_birth,
  output logic [ADDR_WIDTH-1:0]             pair_death,
  output logic [$clog2(PAIR_FIFO_DEPTH):0]  fifo_level,
  output logic                              conflict_flag,
  output logic                              range_err,
  output logic [15:0]                       conflict_count,
  output logic                              flush_done
);

  localparam int unsigned MapW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned PtrW = $clog2(PAIR_FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [1:0] StAccept = 2'd0;
  localparam logic [1:0] StDone   = 2'd2;
`ifdef PERSIST_ESSENTIAL_EN
  localparam logic [1:0] StScan   = 2'd1;
`endif

  logic [1:0]            state_q, state_d;
  logic [NUM_COLS-1:0]   pivot_map_q, pivot_map_d;
  logic                  range_err_q, range_err_d;
  logic                  conflict_flag_q, conflict_flag_d;
  logic [15:0]           conflict_count_q, conflict_count_d;

  logic [ADDR_WIDTH-1:0] birth_mem [PAIR_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] death_mem [PAIR_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q;

  logic                  full, pop, accept, push;
  logic                  col_ok, piv_ok;
  logic [MapW-1:0]       piv_idx;
  logic [ADDR_WIDTH-1:0] push_birth, push_death;

`ifdef PERSIST_ESSENTIAL_EN
  logic [NUM_COLS-1:0]   zero_map_q, zero_map_d;
  logic [MapW-1:0]       k_q, k_d;
  logic [MapW-1:0]       col_idx;
  logic                  scan_need;

  assign col_idx   = in_col[MapW-1:0];
  assign scan_need = zero_map_q[k_q] && !pivot_map_q[k_q];
`endif

  // Fullness comes from the registered level, so a same-cycle pop never frees space.
  assign full     = (level_q == LvlW'(PAIR_FIFO_DEPTH));
  assign in_ready = rst_n && enable && (state_q == StAccept) && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = pair_ready && (level_q != '0);
  assign col_ok   = (32'(in_col) < NUM_COLS);
  assign piv_ok   = (32'(in_pivot) < NUM_COLS);
  assign piv_idx  = in_pivot[MapW-1:0];

  always_comb begin
    state_d          = state_q;
    pivot_map_d      = pivot_map_q;
    range_err_d      = range_err_q;
    conflict_flag_d  = conflict_flag_q;
    conflict_count_d = conflict_count_q;
    push             = 1'b0;
    push_birth       = '0;
    push_death       = '0;
`ifdef PERSIST_ESSENTIAL_EN
    zero_map_d       = zero_map_q;
    k_d              = k_q;
`endif
    case (state_q)
      StAccept: begin
        if (accept) begin
          if (in_zero) begin
`ifdef PERSIST_ESSENTIAL_EN
            if (!col_ok) range_err_d = 1'b1;
            else         zero_map_d[col_idx] = 1'b1;
`endif
          end else if (!col_ok || !piv_ok) begin
            range_err_d = 1'b1;
          end else if (pivot_map_q[piv_idx]) begin
            conflict_flag_d = 1'b1;
            if (conflict_count_q != 16'hFFFF) conflict_count_d = conflict_count_q + 16'd1;
          end else begin
            pivot_map_d[piv_idx] = 1'b1;
            push                 = 1'b1;
            push_birth           = in_pivot;
            push_death           = in_col;
          end
        end
        // The record accepted alongside flush has already been folded in above.
        if (enable && flush) begin
`ifdef PERSIST_ESSENTIAL_EN
          state_d = StScan;
          k_d     = '0;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef PERSIST_ESSENTIAL_EN
      StScan: begin
        if (enable && !(scan_need && full)) begin
          if (scan_need) begin
            push       = 1'b1;
            push_birth = ADDR_WIDTH'(k_q);
            push_death = '1;
          end
          if (k_q == MapW'(NUM_COLS - 1)) state_d = StDone;
          else                            k_d     = k_q + 1'b1;
        end
      end
`endif
      StDone: begin
        state_d     = StAccept;
        pivot_map_d = '0;
`ifdef PERSIST_ESSENTIAL_EN
        zero_map_d  = '0;
        k_d         = '0;
`endif
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StAccept;
      pivot_map_q      <= '0;
      range_err_q      <= 1'b0;
      conflict_flag_q  <= 1'b0;
      conflict_count_q <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
`ifdef PERSIST_ESSENTIAL_EN
      zero_map_q       <= '0;
      k_q              <= '0;
`endif
    end else begin
      state_q          <= state_d;
      pivot_map_q      <= pivot_map_d;
      range_err_q      <= range_err_d;
      conflict_flag_q  <= conflict_flag_d;
      conflict_count_q <= conflict_count_d;
`ifdef PERSIST_ESSENTIAL_EN
      zero_map_q       <= zero_map_d;
      k_q              <= k_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      birth_mem[wr_ptr_q] <= push_birth;
      death_mem[wr_ptr_q] <= push_death;
    end
  end

  assign pair_valid     = (level_q != '0);
  assign pair_birth     = pair_valid ? birth_mem[rd_ptr_q] : '0;
  assign pair_death     = pair_valid ? death_mem[rd_ptr_q] : '0;
  assign fifo_level     = level_q;
  assign conflict_flag  = conflict_flag_q;
  assign range_err      = range_err_q;
  assign conflict_count = conflict_count_q;
  assign flush_done     = (state_q == StDone);

endmodule
